// File: rtl/vline_motion_ctrl_pkg.sv
// Shared definitions for the vertical-line controller: FSM states, default
// screen limits and the position width used by the line counters.
package vline_motion_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_STEP = 2'd2,
    S_LOAD = 2'd3
  } vstate_e;

  localparam int unsigned YW        = 16;
  localparam int unsigned Y_TOP_DEF = 18;
  localparam int unsigned Y_BOT_DEF = 487;

  function automatic logic [YW-1:0] ylim(input int unsigned v);
    return YW'(v);
  endfunction

endpackage

// File: rtl/vline_motion_ctrl_if.sv
// Control/feedback bundle between VGA timing, the line counter and the
// vertical-line motion controller.
interface vline_motion_ctrl_if;
  import vline_motion_ctrl_pkg::*;

  logic          frame_tick;
  logic          go;
  logic          load_req;
  logic [YW-1:0] ycoord;
  logic          y_utc;
  logic          y_dtc;
  logic          UP;
  logic          DW;
  logic          LD;
  logic          dir_down;
  logic          busy;

  modport master (
    output frame_tick, go, load_req, ycoord, y_utc, y_dtc,
    input  UP, DW, LD, dir_down, busy
  );

  modport slave (
    input  frame_tick, go, load_req, ycoord, y_utc, y_dtc,
    output UP, DW, LD, dir_down, busy
  );
endinterface

// File: rtl/vline_motion_ctrl_timer.sv
// Frame divider: counts frame ticks while enabled and flags the tick that
// completes each group of FRAME_DIV frames.
module frame_step_timer #(
  parameter int unsigned FRAME_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_tick,
  input  logic i_en,
  input  logic i_clr,
  output logic o_step_due
);
  logic [7:0] r_div;
  logic       w_last;

  assign w_last     = (r_div == 8'(FRAME_DIV - 1));
  assign o_step_due = i_en && !i_clr && i_tick && w_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              r_div <= '0;
    else if (i_clr)          r_div <= '0;
    else if (i_en && i_tick) r_div <= w_last ? 8'd0 : r_div + 8'd1;
  end
endmodule

// File: rtl/vline_motion_ctrl.sv
// Bounces the vertical line between Y_TOP and Y_BOT by strobing the line
// counter's UP/DW/LD inputs at a frame-synchronous rate.
module vline_motion_ctrl
  import vline_motion_ctrl_pkg::*;
#(
  parameter int unsigned Y_TOP     = Y_TOP_DEF,
  parameter int unsigned Y_BOT     = Y_BOT_DEF,
  parameter int unsigned FRAME_DIV = 4,
  parameter int unsigned STEP_PX   = 2
) (
  input  logic                clk,
  input  logic                reset,
  vline_motion_ctrl_if.slave  bus
);
  vstate_e    r_state, w_state_nxt;
  logic       r_phase, w_phase_nxt;
  logic [3:0] r_burst, w_burst_nxt;
  logic       r_dir, w_dir_nxt;
  logic       r_up, r_dw, r_ld, r_busy;
  logic       w_up, w_dw, w_ld;
  logic       w_ld_acc, w_step_due, w_clr, w_at_bot, w_at_top;

  // A second request right on the LD cycle would make LD two cycles long.
  assign w_ld_acc = bus.load_req && !(r_state == S_LOAD && !r_phase);
  assign w_clr    = !bus.go || w_ld_acc || (r_state != S_WAIT);
  assign w_at_bot = bus.y_utc || (bus.ycoord >= ylim(Y_BOT));
  assign w_at_top = bus.y_dtc || (bus.ycoord <= ylim(Y_TOP));

  frame_step_timer #(.FRAME_DIV(FRAME_DIV)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_tick     (bus.frame_tick),
    .i_en       (r_state == S_WAIT),
    .i_clr      (w_clr),
    .o_step_due (w_step_due)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_burst_nxt = r_burst;
    w_dir_nxt   = r_dir;
    w_up        = 1'b0;
    w_dw        = 1'b0;
    w_ld        = 1'b0;
    if (w_ld_acc) begin
      w_state_nxt = S_LOAD;
      w_phase_nxt = 1'b0;
      w_burst_nxt = '0;
      w_ld        = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: if (bus.go) w_state_nxt = S_WAIT;
        S_WAIT: begin
          if (!bus.go) w_state_nxt = S_IDLE;
          else if (w_step_due) begin
            w_state_nxt = S_STEP;
            w_phase_nxt = 1'b0;
            w_burst_nxt = 4'(STEP_PX);
          end
        end
        S_STEP: begin
          if (!bus.go) begin
            w_state_nxt = S_IDLE;
            w_phase_nxt = 1'b0;
            w_burst_nxt = '0;
          end else if (r_phase) begin
            // Gap cycle: the counter has absorbed the last strobe by now.
            w_phase_nxt = 1'b0;
            if (r_burst == '0) w_state_nxt = S_WAIT;
          end else if (r_dir ? w_at_bot : w_at_top) begin
            w_dir_nxt   = !r_dir;
            w_burst_nxt = '0;
            w_state_nxt = S_WAIT;
          end else begin
            w_phase_nxt = 1'b1;
            w_burst_nxt = r_burst - 4'd1;
            w_up        = r_dir;
            w_dw        = !r_dir;
          end
        end
        S_LOAD: begin
          if (!r_phase) w_phase_nxt = 1'b1;
          else begin
            w_phase_nxt = 1'b0;
            if (bus.ycoord < ylim(Y_TOP))      w_dir_nxt = 1'b1;
            else if (bus.ycoord > ylim(Y_BOT)) w_dir_nxt = 1'b0;
            w_state_nxt = bus.go ? S_WAIT : S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_phase <= 1'b0;
      r_burst <= '0;
      r_dir   <= 1'b1;
      r_up    <= 1'b0;
      r_dw    <= 1'b0;
      r_ld    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_burst <= w_burst_nxt;
      r_dir   <= w_dir_nxt;
      r_up    <= w_up;
      r_dw    <= w_dw;
      r_ld    <= w_ld;
      r_busy  <= (w_state_nxt == S_STEP);
    end
  end

  assign bus.UP       = r_up;
  assign bus.DW       = r_dw;
  assign bus.LD       = r_ld;
  assign bus.dir_down = r_dir;
  assign bus.busy     = r_busy;
endmodule
